dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 271 +++++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester round-robin arbiter in front of a single-port data memory.
// Requester 0 is the core load/store unit, requester 1 is a DMA/debug port.
// Each granted access takes three cycles: IDLE (grant), ACCESS (memory
// strobe), RESP (one-cycle ack to the owner). All outputs come straight
// from flops, so no requester input reaches the memory strobes
// combinationally.
//
// Parameters
//   ADDR_W  word address width of requester and memory buses
//   DATA_W  data width
//   DEPTH   number of valid memory words; addresses >= DEPTH are rejected
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   m0_req/we/addr/wdata        requester 0 access request and fields
//   m0_ack/err/rdata            requester 0 completion pulse, range error,
//                               read data (all valid only with ack)
//   m1_*                        same set for requester 1
//   mem_we/re/addr/wdata        memory strobes, address and write data
//   mem_rdata                   combinational read data from memory
//   busy                        high while the FSM is not IDLE
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  // Word address lies inside the populated memory
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (addr < DEPTH_LIM);
  endfunction

  // FSM and transaction context
  state_t              state_r, state_s;
  logic                ptr_r, ptr_s;        // 0: requester 0 wins a tie
  logic                owner_r, owner_s;
  logic                we_r, we_s;
  logic                ok_r, ok_s;          // latched address is in range
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [DATA_W-1:0]   wdata_r, wdata_s;

  // Registered outputs and their next values
  logic                mem_we_r, mem_we_s;
  logic                mem_re_r, mem_re_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
  logic                m0_ack_r, m0_ack_s;
  logic                m0_err_r, m0_err_s;
  logic [DATA_W-1:0]   m0_rdata_r, m0_rdata_s;
  logic                m1_ack_r, m1_ack_s;
  logic                m1_err_r, m1_err_s;
  logic [DATA_W-1:0]   m1_rdata_r, m1_rdata_s;
  logic                busy_r, busy_s;

  // Grant selection helpers
  logic                gnt_id_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic                sel_ok_s;
  logic [DATA_W-1:0]   rsp_data_s;
  logic                rsp_err_s;

  // Winner selection: the pointer only matters when both requests are high
  always_comb begin
    gnt_id_s = 1'b0;
    if (m0_req && m1_req) begin
      gnt_id_s = ptr_r;
    end else if (m1_req) begin
      gnt_id_s = 1'b1;
    end else begin
      gnt_id_s = 1'b0;
    end
  end

  // Field mux for the selected requester
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = ADDR_ZERO;
    sel_wdata_s = DATA_ZERO;
    if (gnt_id_s) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end
    sel_ok_s = addr_in_range(sel_addr_s);
  end

  // Response payload: reads of valid words return memory data, else zero
  always_comb begin
    rsp_data_s = DATA_ZERO;
    rsp_err_s  = !ok_r;
    if (!we_r && ok_r) begin
      rsp_data_s = mem_rdata;
    end else begin
      rsp_data_s = DATA_ZERO;
    end
  end

  // Next-state, latched context and next registered outputs
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    owner_s     = owner_r;
    we_s        = we_r;
    ok_s        = ok_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    mem_we_s    = 1'b0;
    mem_re_s    = 1'b0;
    mem_addr_s  = ADDR_ZERO;
    mem_wdata_s = DATA_ZERO;
    m0_ack_s    = 1'b0;
    m0_err_s    = 1'b0;
    m0_rdata_s  = DATA_ZERO;
    m1_ack_s    = 1'b0;
    m1_err_s    = 1'b0;
    m1_rdata_s  = DATA_ZERO;

    case (state_r)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          state_s     = ST_ACCESS;
          ptr_s       = !gnt_id_s;
          owner_s     = gnt_id_s;
          we_s        = sel_we_s;
          ok_s        = sel_ok_s;
          addr_s      = sel_addr_s;
          wdata_s     = sel_wdata_s;
          // Strobes are prepared here so they sit in flops during ACCESS
          mem_addr_s  = sel_addr_s;
          mem_wdata_s = sel_wdata_s;
          mem_we_s    = sel_we_s && sel_ok_s;
          mem_re_s    = !sel_we_s && sel_ok_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_s = ST_RESP;
        // Memory data is captured at the end of ACCESS straight into the
        // owner's response register
        if (owner_r) begin
          m1_ack_s   = 1'b1;
          m1_err_s   = rsp_err_s;
          m1_rdata_s = rsp_data_s;
        end else begin
          m0_ack_s   = 1'b1;
          m0_err_s   = rsp_err_s;
          m0_rdata_s = rsp_data_s;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // FSM state, round-robin pointer and latched transaction context
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= 1'b0;
      owner_r <= 1'b0;
      we_r    <= 1'b0;
      ok_r    <= 1'b0;
      addr_r  <= ADDR_ZERO;
      wdata_r <= DATA_ZERO;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      owner_r <= owner_s;
      we_r    <= we_s;
      ok_r    <= ok_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
    end
  end

  // Output registers; reset clears them at once, aborting any memory strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we_r    <= 1'b0;
      mem_re_r    <= 1'b0;
      mem_addr_r  <= ADDR_ZERO;
      mem_wdata_r <= DATA_ZERO;
      m0_ack_r    <= 1'b0;
      m0_err_r    <= 1'b0;
      m0_rdata_r  <= DATA_ZERO;
      m1_ack_r    <= 1'b0;
      m1_err_r    <= 1'b0;
      m1_rdata_r  <= DATA_ZERO;
      busy_r      <= 1'b0;
    end else begin
      mem_we_r    <= mem_we_s;
      mem_re_r    <= mem_re_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      m0_ack_r    <= m0_ack_s;
      m0_err_r    <= m0_err_s;
      m0_rdata_r  <= m0_rdata_s;
      m1_ack_r    <= m1_ack_s;
      m1_err_r    <= m1_err_s;
      m1_rdata_r  <= m1_rdata_s;
      busy_r      <= busy_s;
    end
  end

  assign mem_we    = mem_we_r;
  assign mem_re    = mem_re_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign m0_ack    = m0_ack_r;
  assign m0_err    = m0_err_r;
  assign m0_rdata  = m0_rdata_r;
  assign m1_ack    = m1_ack_r;
  assign m1_err    = m1_err_r;
  assign m1_rdata  = m1_rdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter. A small memory model answers reads
// combinationally and commits writes on the rising edge. Inputs are driven
// and outputs sampled on the falling edge. Unwritten words hold the pattern
// 32'hA000_0000 | address.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_ack, m0_err, m1_ack, m1_err;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              busy;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [4:0]        ctl;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  // {busy, mem_we, mem_re, m0_ack, m1_ack}
  assign ctl = {busy, mem_we, mem_re, m0_ack, m1_ack};

  assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'h0000_0000;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory model: preload pattern, then commit writes on each rising edge
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 | i;
    forever begin
      @(posedge clk);
      if (mem_we && mem_addr < 32'd1024) mem[mem_addr[9:0]] <= mem_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd4; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
    step(); step();
    chk_cnt++;
    if (ctl !== 5'b00000) $display("FAIL reset_ctl got %b want %b", ctl, 5'b00000);
    else pass_cnt++;
    chk_cnt++;
    if ({mem_addr, m0_rdata, m1_rdata} !== 96'd0)
      $display("FAIL reset_data got %h/%h/%h want 0", mem_addr, m0_rdata, m1_rdata);
    else pass_cnt++;
    m0_req = 1'b0;
    rst = 1'b1;
    step();
    chk_cnt++;
    if (ctl !== 5'b00000) $display("FAIL reset_idle got %b want %b", ctl, 5'b00000);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd5; m0_wdata = 32'hDEAD_BEEF;
    step();
    chk_cnt++;
    if (ctl !== 5'b11000 || mem_addr !== 32'd5 || mem_wdata !== 32'hDEAD_BEEF)
      $display("FAIL wr_access got %b %h %h want 11000 5 deadbeef", ctl, mem_addr, mem_wdata);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (ctl !== 5'b10010 || m0_err !== 1'b0 || m0_rdata !== 32'd0)
      $display("FAIL wr_ack got %b err %b rd %h want 10010 0 0", ctl, m0_err, m0_rdata);
    else pass_cnt++;
    m0_req = 1'b0;
    step();
    chk_cnt++;
    if (ctl !== 5'b00000 || mem[5] !== 32'hDEAD_BEEF)
      $display("FAIL wr_commit got %b mem %h want 00000 deadbeef", ctl, mem[5]);
    else pass_cnt++;
    m0_req = 1'b1; m0_we = 1'b0; m0_wdata = 32'd0;
    step();
    chk_cnt++;
    if (ctl !== 5'b10100 || mem_addr !== 32'd5)
      $display("FAIL rd_access got %b %h want 10100 5", ctl, mem_addr);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (ctl !== 5'b10010 || m0_rdata !== 32'hDEAD_BEEF || m0_err !== 1'b0)
      $display("FAIL rd_ack got %b %h err %b want 10010 deadbeef 0", ctl, m0_rdata, m0_err);
    else pass_cnt++;
    m0_req = 1'b0;
    step();
    chk_cnt++;
    if (ctl !== 5'b00000) $display("FAIL rd_done got %b want 00000", ctl);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    rst = 1'b0;
    #2;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd9;
    rst = 1'b1;
    step();
    chk_cnt++;
    if (ctl !== 5'b10100 || mem_addr !== 32'd1)
      $display("FAIL sim_first_grant got %b %h want 10100 1", ctl, mem_addr);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (ctl !== 5'b10010 || m0_rdata !== 32'hA000_0001 || m1_rdata !== 32'd0)
      $display("FAIL sim_m0_ack got %b %h %h want 10010 a0000001 0", ctl, m0_rdata, m1_rdata);
    else pass_cnt++;
    m0_req = 1'b0;
    step();
    step();
    chk_cnt++;
    if (ctl !== 5'b10100 || mem_addr !== 32'd9)
      $display("FAIL sim_second_grant got %b %h want 10100 9", ctl, mem_addr);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (ctl !== 5'b10001 || m1_rdata !== 32'hA000_0009 || m1_err !== 1'b0 || m0_rdata !== 32'd0)
      $display("FAIL sim_m1_ack got %b %h err %b want 10001 a0000009 0", ctl, m1_rdata, m1_err);
    else pass_cnt++;
    m1_req = 1'b0;
    step();
  endtask

  task automatic test_fairness();
    int n_ack;
    logic [DATA_W-1:0] want;
    n_ack = 0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd2;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd3;
    for (int c = 0; c < 12; c++) begin
      step();
      if (m0_ack || m1_ack) begin
        // Order must be m0, m1, m0, m1 since the pointer now favours m0
        if (n_ack % 2 == 0) want = 32'hA000_0002;
        else want = 32'hA000_0003;
        chk_cnt++;
        if ((n_ack % 2 == 0) && (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m0_rdata !== want))
          $display("FAIL fair_ack%0d got m0 %b m1 %b %h want m0 ack %h", n_ack, m0_ack, m1_ack, m0_rdata, want);
        else if ((n_ack % 2 == 1) && (m1_ack !== 1'b1 || m0_ack !== 1'b0 || m1_rdata !== want))
          $display("FAIL fair_ack%0d got m0 %b m1 %b %h want m1 ack %h", n_ack, m0_ack, m1_ack, m1_rdata, want);
        else pass_cnt++;
        n_ack++;
      end
    end
    chk_cnt++;
    if (n_ack !== 4) $display("FAIL fair_count got %0d want 4", n_ack);
    else pass_cnt++;
    m0_req = 1'b0; m1_req = 1'b0;
    step();
  endtask

  task automatic test_out_of_range();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'd1024; m1_wdata = 32'h1;
    step();
    chk_cnt++;
    if (ctl !== 5'b10000) $display("FAIL oor_wr_strobe got %b want 10000", ctl);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (ctl !== 5'b10001 || m1_err !== 1'b1 || m1_rdata !== 32'd0)
      $display("FAIL oor_wr_ack got %b err %b %h want 10001 1 0", ctl, m1_err, m1_rdata);
    else pass_cnt++;
    m1_req = 1'b0;
    step();
    m1_req = 1'b1; m1_we = 1'b0; m1_wdata = 32'd0;
    step();
    chk_cnt++;
    if (ctl !== 5'b10000) $display("FAIL oor_rd_strobe got %b want 10000", ctl);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (ctl !== 5'b10001 || m1_err !== 1'b1 || m1_rdata !== 32'd0)
      $display("FAIL oor_rd_ack got %b err %b %h want 10001 1 0", ctl, m1_err, m1_rdata);
    else pass_cnt++;
    m1_req = 1'b0;
    step();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd1023;
    step();
    chk_cnt++;
    if (ctl !== 5'b10100) $display("FAIL last_word_strobe got %b want 10100", ctl);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (ctl !== 5'b10010 || m0_err !== 1'b0 || m0_rdata !== 32'hA000_03FF)
      $display("FAIL last_word_ack got %b err %b %h want 10010 0 a00003ff", ctl, m0_err, m0_rdata);
    else pass_cnt++;
    m0_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_access();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd3; m0_wdata = 32'h55;
    step();
    chk_cnt++;
    if (ctl !== 5'b11000) $display("FAIL rma_access got %b want 11000", ctl);
    else pass_cnt++;
    #1 rst = 1'b0;
    #1;
    chk_cnt++;
    if (ctl !== 5'b00000 || mem_addr !== 32'd0 || mem_wdata !== 32'd0)
      $display("FAIL rma_async_clear got %b %h %h want 00000 0 0", ctl, mem_addr, mem_wdata);
    else pass_cnt++;
    m0_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_cnt++;
    if (ctl !== 5'b00000 || mem[3] !== 32'hA000_0003)
      $display("FAIL rma_no_commit got %b mem %h want 00000 a0000003", ctl, mem[3]);
    else pass_cnt++;
  endtask

  task automatic test_owner_drop();
    int n_ack;
    n_ack = 0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd7;
    step();
    chk_cnt++;
    if (ctl !== 5'b10100 || mem_addr !== 32'd7)
      $display("FAIL drop_grant got %b %h want 10100 7", ctl, mem_addr);
    else pass_cnt++;
    m1_req = 1'b0; m1_addr = 32'd8;
    for (int c = 0; c < 4; c++) begin
      step();
      if (m1_ack) begin
        n_ack++;
        chk_cnt++;
        if (m1_rdata !== 32'hA000_0007 || m1_err !== 1'b0)
          $display("FAIL drop_rdata got %h err %b want a0000007 0", m1_rdata, m1_err);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (n_ack !== 1) $display("FAIL drop_ack_count got %0d want 1", n_ack);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_simultaneous();
    test_fairness();
    test_out_of_range();
    test_reset_mid_access();
    test_owner_drop();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
